// File: rtl/fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_loader
// Description : FFT input stage. Stores a streamed real frame at bit-reversed
//               addresses, then drains it as first-stage butterfly pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_loader #(
    parameter int                 LOG2N = 4,
    parameter int                 IW    = 16,
    parameter logic signed [15:0] W_ONE = 16'sd16384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    output logic          in_ready,
    input  logic          out_hold,
    output logic [31:0]   xa_r,
    output logic [31:0]   xa_i,
    output logic [31:0]   xb_r,
    output logic [31:0]   xb_i,
    output logic [15:0]   w_r,
    output logic [15:0]   w_i,
    output logic          enable,
    output logic          frame_done
);

    localparam int c_N  = 2 ** LOG2N;
    localparam int c_RW = LOG2N - 1;

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LOG2N-1:0]   r_wr_cnt;
    logic [c_RW-1:0]    r_rd_cnt;
    logic [31:0]        r_mem [c_N];

    logic               w_accept;
    logic               w_emit;
    logic               w_last;
    logic [LOG2N-1:0]   w_wr_addr;
    logic [LOG2N-1:0]   w_rd_addr_a;
    logic [LOG2N-1:0]   w_rd_addr_b;
    logic [31:0]        w_sext;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_accept = in_valid;
                if (in_valid && (r_wr_cnt == LOG2N'(c_N - 1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_emit = !out_hold;
                w_last = !out_hold && (r_rd_cnt == {c_RW{1'b1}});
                if (w_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        w_wr_addr = '0;
        for (int b = 0; b < LOG2N; b++) begin
            w_wr_addr[b] = r_wr_cnt[LOG2N-1-b];
        end
    end

    assign w_rd_addr_a = {r_rd_cnt, 1'b0};
    assign w_rd_addr_b = {r_rd_cnt, 1'b1};
    assign w_sext      = 32'($signed(in_data));
    assign in_ready    = (r_state == S_LOAD);

    // Buffer has no reset; a write in a reset cycle is suppressed so rst wins.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mem[w_wr_addr] <= w_sext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            xa_r       <= '0;
            xa_i       <= '0;
            xb_r       <= '0;
            xb_i       <= '0;
            w_r        <= '0;
            w_i        <= '0;
            enable     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            enable     <= w_emit;
            frame_done <= w_last;
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            end
            if (w_emit) begin
                xa_r     <= r_mem[w_rd_addr_a];
                xb_r     <= r_mem[w_rd_addr_b];
                xa_i     <= '0;
                xb_i     <= '0;
                w_r      <= W_ONE;
                w_i      <= '0;
                r_rd_cnt <= r_rd_cnt + c_RW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitrev_loader
// Description : Randomized self-checking bench with a queue-based pair model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_loader;

    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int NP    = N / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_hold;
    logic [31:0] xa_r, xa_i, xb_r, xb_i;
    logic [15:0] w_r, w_i;
    logic        enable;
    logic        frame_done;

    fft_bitrev_loader #(.LOG2N(LOG2N), .IW(16), .W_ONE(16'sd16384)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_hold   (out_hold),
        .xa_r       (xa_r),
        .xa_i       (xa_i),
        .xb_r       (xb_r),
        .xb_i       (xb_i),
        .w_r        (w_r),
        .w_i        (w_i),
        .enable     (enable),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef int frame_t [N];
    typedef struct {
        int xa;
        int xb;
        bit done;
    } pair_t;

    pair_t exp_q [$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    logic  rst_q    = 1'b0;
    bit    mon_en   = 1'b0;
    int    en_cnt   = 0;
    int    first_en = 0;
    int    last_en  = 0;
    int    e0       = 0;
    logic [31:0] l_xa = '0, l_xb = '0, l_w = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + ((x >> b) & 1);
        end
        return r;
    endfunction

    // Pair k reads buffer slots 2k and 2k+1, which hold samples brev(2k), brev(2k+1).
    task automatic push_frame(input frame_t s);
        for (int k = 0; k < NP; k++) begin
            pair_t p;
            logic signed [15:0] a, b;
            a      = s[brev(2 * k)][15:0];
            b      = s[brev(2 * k + 1)][15:0];
            p.xa   = a;
            p.xb   = b;
            p.done = (k == NP - 1);
            exp_q.push_back(p);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                chk("rst_xa_r", xa_r, 0);
                chk("rst_xb_r", xb_r, 0);
                chk("rst_xa_i", xa_i, 0);
                chk("rst_xb_i", xb_i, 0);
                chk("rst_w", {w_r, w_i}, 0);
                chk("rst_enable", 32'(enable), 0);
                chk("rst_frame_done", 32'(frame_done), 0);
                l_xa = '0;
                l_xb = '0;
                l_w  = '0;
            end else if (enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_enable", 32'(enable), 0);
                end else begin
                    pair_t p;
                    p = exp_q.pop_front();
                    chk("pair_xa_r", xa_r, p.xa);
                    chk("pair_xb_r", xb_r, p.xb);
                    chk("pair_frame_done", 32'(frame_done), 32'(p.done));
                end
                chk("pair_xa_i", xa_i, 0);
                chk("pair_xb_i", xb_i, 0);
                chk("pair_w_r", 32'(w_r), 16384);
                chk("pair_w_i", 32'(w_i), 0);
                en_cnt++;
                if (en_cnt == 1) first_en = cyc;
                last_en = cyc;
                l_xa = xa_r;
                l_xb = xb_r;
                l_w  = {w_r, w_i};
            end else begin
                chk("idle_enable", 32'(enable), 0);
                chk("idle_frame_done", 32'(frame_done), 0);
                chk("hold_xa_r", xa_r, l_xa);
                chk("hold_xb_r", xb_r, l_xb);
                chk("hold_w", {w_r, w_i}, l_w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int n);
        int t = 0;
        while (en_cnt < n && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (en_cnt < n) chk("timeout_enable", en_cnt, n);
    endtask

    // gap_mode: 0 = none, 1 = one idle cycle after each sample, 2 = random 0..2
    task automatic send_frame(input frame_t s, input int gap_mode, input bit rnd_hold);
        for (int i = 0; i < N; i++) begin
            int t = 0;
            int g;
            in_valid = 1'b1;
            in_data  = s[i][15:0];
            if (rnd_hold) out_hold = 1'($urandom_range(0, 1));
            while (!in_ready && t < 200) begin
                tick();
                t++;
            end
            if (!in_ready) begin
                chk("timeout_ready", 32'(in_ready), 1);
                in_valid = 1'b0;
                return;
            end
            if (i == N - 1) push_frame(s);
            tick();
            chk("ready_after_accept", 32'(in_ready), (i == N - 1) ? 0 : 1);
            if (i == N - 1) e0 = cyc;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (g > 0 && i != N - 1) begin
                in_valid = 1'b0;
                for (int j = 0; j < g; j++) tick();
            end
        end
        in_valid = 1'b0;
        out_hold = 1'b0;
    endtask

    task automatic drain_all(input bit rnd_hold);
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            out_hold = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            t++;
        end
        out_hold = 1'b0;
        if (exp_q.size() > 0) chk("timeout_drain", exp_q.size(), 0);
        chk("ready_after_drain", 32'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t s;
        int     rlow;
        frame_t b2;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        out_hold = 1'b0;
        mon_en   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 1);

        // Ascending 1..16, continuous valid; checks drain latency.
        for (int i = 0; i < N; i++) s[i] = i + 1;
        en_cnt = 0;
        send_frame(s, 0, 1'b0);
        drain_all(1'b0);
        chk("s1_enables", en_cnt, NP);
        chk("s1_first_latency", first_en, e0 + 1);
        chk("s1_last_latency", last_en, e0 + NP);

        // Sign extension of extremes.
        for (int i = 0; i < N; i++) s[i] = 0;
        s[0] = 32'h8000;
        s[8] = 32'hFFFF;
        en_cnt = 0;
        send_frame(s, 0, 1'b0);
        drain_all(1'b0);
        chk("s2_enables", en_cnt, NP);

        // Alternating valid.
        for (int i = 0; i < N; i++) s[i] = i + 1;
        en_cnt = 0;
        send_frame(s, 1, 1'b0);
        drain_all(1'b0);
        chk("s3_enables", en_cnt, NP);

        // Stall for 3 cycles after pair 2 while junk is offered on the input.
        for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 65535));
        en_cnt = 0;
        send_frame(s, 0, 1'b0);
        wait_en(3);
        out_hold = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd99;
        for (int j = 0; j < 3; j++) begin
            chk("s4_ready_in_drain", 32'(in_ready), 0);
            tick();
        end
        out_hold = 1'b0;
        in_valid = 1'b0;
        chk("s4_enables_during_hold", en_cnt, 3);
        drain_all(1'b0);
        chk("s4_enables", en_cnt, NP);

        // Reset after pair 4 abandons the drain.
        for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 65535));
        en_cnt = 0;
        send_frame(s, 0, 1'b0);
        wait_en(5);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("s5_ready_after_rst", 32'(in_ready), 1);
        for (int j = 0; j < 4; j++) tick();
        chk("s5_no_more_enables", en_cnt, 5);
        for (int i = 0; i < N; i++) s[i] = 101 + i;
        en_cnt = 0;
        send_frame(s, 0, 1'b0);
        drain_all(1'b0);
        chk("s5_new_frame_enables", en_cnt, NP);

        // Back-to-back frames with valid held high throughout.
        for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 65535));
        for (int i = 0; i < N; i++) b2[i] = int'($urandom_range(0, 65535));
        rlow   = 0;
        en_cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = (i < N) ? s[i][15:0] : b2[i-N][15:0];
            while (!in_ready && t < 200) begin
                rlow++;
                tick();
                t++;
            end
            if (i == N - 1) push_frame(s);
            if (i == 2 * N - 1) push_frame(b2);
            tick();
        end
        in_valid = 1'b0;
        drain_all(1'b0);
        chk("s6_ready_low_cycles", rlow, NP);
        chk("s6_enables", en_cnt, 2 * NP);

        // Random frames with random gaps and random stalls (stall ignored in LOAD).
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 65535));
            en_cnt = 0;
            send_frame(s, 2, 1'b1);
            drain_all(1'b1);
            chk("rnd_enables", en_cnt, NP);
        end

        tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
